// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared widths and state encoding for the image word packer
package img_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [0:0] {
        ACC   = 1'b0,
        TRAIL = 1'b1
    } packer_state_t;

endpackage

// File: rtl/img_word_packer.sv
// rtl/img_word_packer.sv - packs pixel bytes little-endian into 32-bit words with optional byte-count trailer
module img_word_packer
    import img_pkg::*;
#(
    parameter bit EMIT_TRAILER = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BYTE_W-1:0] pix_data,
    input  logic              pix_valid,
    input  logic              pix_last,
    output logic              pix_stall,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              downstream_stall
);

    packer_state_t     state, state_nxt;
    logic [WORD_W-1:0] acc_word, acc_word_nxt;
    logic [2:0]        acc_cnt, acc_cnt_nxt;
    logic              acc_last, acc_last_nxt;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
    // A next-frame byte taken in the same cycle the final word loads must not
    // inflate the trailer; it is remembered here and seeds the next count.
    logic              carry, carry_nxt;
    logic [WORD_W-1:0] out_data_nxt;
    logic              out_valid_nxt;
    logic [WORD_W-1:0] cnt_ext;

    logic word_ready;
    logic out_free;
    logic accept;
    logic load;

    assign word_ready = (acc_cnt == 3'(BYTES_PER_WORD)) || acc_last;
    assign out_free   = !out_valid || !downstream_stall;
    assign pix_stall  = (state == TRAIL) || (word_ready && !out_free);
    assign accept     = pix_valid && !pix_stall;
    assign load       = (state == ACC) && word_ready && out_free;

    // Zero-extend the frame byte count into a full trailer word.
    always_comb begin
        cnt_ext = '0;
        cnt_ext[CNT_W-1:0] = byte_cnt;
    end

    // Next-state, accumulator and output-register update.
    always_comb begin
        state_nxt     = state;
        acc_word_nxt  = acc_word;
        acc_cnt_nxt   = acc_cnt;
        acc_last_nxt  = acc_last;
        byte_cnt_nxt  = byte_cnt;
        carry_nxt     = carry;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;

        if (out_free) begin
            out_valid_nxt = 1'b0;
        end

        case (state)
            ACC: begin
                if (load) begin
                    out_data_nxt  = acc_word;
                    out_valid_nxt = 1'b1;
                    acc_word_nxt  = '0;
                    acc_cnt_nxt   = 3'd0;
                    acc_last_nxt  = 1'b0;
                    if (accept) begin
                        acc_word_nxt[BYTE_W-1:0] = pix_data;
                        acc_cnt_nxt              = 3'd1;
                        acc_last_nxt             = pix_last;
                    end
                    if (acc_last) begin
                        if (EMIT_TRAILER) begin
                            state_nxt = TRAIL;
                            carry_nxt = accept;
                        end else begin
                            byte_cnt_nxt = CNT_W'(accept);
                        end
                    end else if (accept) begin
                        byte_cnt_nxt = byte_cnt + CNT_W'(1);
                    end
                end else if (accept) begin
                    acc_word_nxt[BYTE_W*acc_cnt[1:0] +: BYTE_W] = pix_data;
                    acc_cnt_nxt  = acc_cnt + 3'd1;
                    byte_cnt_nxt = byte_cnt + CNT_W'(1);
                    if (pix_last) begin
                        acc_last_nxt = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (out_free) begin
                    out_data_nxt  = cnt_ext;
                    out_valid_nxt = 1'b1;
                    byte_cnt_nxt  = CNT_W'(carry);
                    carry_nxt     = 1'b0;
                    state_nxt     = ACC;
                end
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    // Register all state; reset discards any partial word and pending output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ACC;
            acc_word  <= '0;
            acc_cnt   <= 3'd0;
            acc_last  <= 1'b0;
            byte_cnt  <= '0;
            carry     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc_word  <= acc_word_nxt;
            acc_cnt   <= acc_cnt_nxt;
            acc_last  <= acc_last_nxt;
            byte_cnt  <= byte_cnt_nxt;
            carry     <= carry_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule
